// File: rtl/pe_result_drain_if.sv
// pe_result_drain_if
//   Bundles the PE-side drain strobes and the memory-writer stream of
//   pe_result_drain.
//   master (drain block): drives wben, out_ready, m_valid, m_data, m_idx;
//                         samples pe_sum, m_ready.
//   slave  (PE column + memory writer): the reverse directions.
//   pe_sum carries PE k's out_sum on bits [32k+31:32k]; m_data uses the same
//   lane packing. m_idx is the accumulator slot of the beat on m_data.
interface pe_result_drain_if #(
  parameter int N    = 4,
  parameter int REGS = 4
);
  localparam int IW = (REGS > 1) ? $clog2(REGS) : 1;

  logic [N-1:0]      wben;
  logic [N-1:0]      out_ready;
  logic [32*N-1:0]   pe_sum;
  logic              m_valid;
  logic              m_ready;
  logic [32*N-1:0]   m_data;
  logic [IW-1:0]     m_idx;

  modport master (
    output wben, out_ready, m_valid, m_data, m_idx,
    input  pe_sum, m_ready
  );

  modport slave (
    input  wben, out_ready, m_valid, m_data, m_idx,
    output pe_sum, m_ready
  );
endinterface

// File: rtl/pe_result_drain.sv
// pe_result_drain
//   Writeback stage behind one column of N systolic PEs. On start it strobes
//   the PEs' out_ready once per accumulator slot (wben held high meanwhile),
//   captures the N parallel out_sum words one cycle later into a small FIFO,
//   and streams them to the memory writer tagged with the slot index. done
//   pulses once all REGS beats have been accepted.
//
//   Ports:
//     clk, rst      system clock, asynchronous active-high reset
//     start         drain request pulse, honoured only while idle
//     bus           pe_result_drain_if.master (PE strobes + output stream)
//     busy          high from accepted start until done
//     done          one-cycle completion pulse
//     stall_cnt     cycles with m_valid & !m_ready since the last start
//
//   Build option: define WB_STALL_CNT_EN to implement the stall counter;
//   otherwise stall_cnt is tied to zero.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start
//   DRAIN  | wben high, issuing out_ready strobes as FIFO credit allows
//   FLUSH  | all slots issued, waiting for the FIFO to empty downstream
//   DONE   | one-cycle done pulse, then back to IDLE
module pe_result_drain #(
  parameter int N     = 4,
  parameter int REGS  = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  pe_result_drain_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);
  localparam int IW = (REGS > 1) ? $clog2(REGS) : 1;
  localparam int CW = $clog2(REGS + 1);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int W  = 32 * N;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] accepted_q, accepted_d;
  logic          cap_pend_q, cap_pend_d;
  logic [IW-1:0] cap_tag_q, cap_tag_d;
  logic [FW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          m_valid_q, m_valid_d;
  logic [W-1:0]  m_data_q, m_data_d;
  logic [IW-1:0] m_idx_q, m_idx_d;

  logic [W-1:0]  mem_data_q [DEPTH];
  logic [IW-1:0] mem_tag_q  [DEPTH];

  logic issue, push, pop, head_from_push;

  // The credit check includes the capture still in flight, so the
  // unconditional push one cycle later always has a free entry.
  always_comb begin
    issue = (state_q == S_DRAIN) && (int'(issued_q) < REGS) &&
            (int'(count_q) + int'(cap_pend_q) + 1 <= DEPTH);
    push  = cap_pend_q;
    pop   = m_valid_q && bus.m_ready;
  end

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q + CW'(issue);
    accepted_d = accepted_q + CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_DRAIN;
          issued_d   = '0;
          accepted_d = '0;
        end
      end
      S_DRAIN: if (int'(issued_d) == REGS)   state_d = S_FLUSH;
      S_FLUSH: if (int'(accepted_d) == REGS) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cap_pend_d = issue;
    cap_tag_d  = issue ? issued_q[IW-1:0] : cap_tag_q;
  end

  // Output head is registered: it is loaded with whatever entry will sit at
  // the FIFO head after this cycle's push/pop, and held when the FIFO drains
  // empty so m_data keeps its last value.
  always_comb begin
    count_d        = count_q + FW'(push) - FW'(pop);
    wr_ptr_d       = wr_ptr_q + PW'(push);
    rd_ptr_d       = rd_ptr_q + PW'(pop);
    m_valid_d      = (count_d != '0);
    head_from_push = (count_q == '0) || (pop && (count_q == FW'(1)));
    m_data_d       = m_data_q;
    m_idx_d        = m_idx_q;
    if (m_valid_d) begin
      if (head_from_push) begin
        m_data_d = bus.pe_sum;
        m_idx_d  = cap_tag_q;
      end else begin
        m_data_d = mem_data_q[rd_ptr_d];
        m_idx_d  = mem_tag_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      accepted_q <= '0;
      cap_pend_q <= 1'b0;
      cap_tag_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_idx_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      cap_pend_q <= cap_pend_d;
      cap_tag_q  <= cap_tag_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_idx_q    <= m_idx_d;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.pe_sum;
      mem_tag_q[wr_ptr_q]  <= cap_tag_q;
    end
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_IDLE) && start)
      stall_d = '0;
    else if (m_valid_q && !bus.m_ready && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign bus.wben      = {N{state_q == S_DRAIN}};
  assign bus.out_ready = {N{issue}};
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_idx     = m_idx_q;
  assign busy          = (state_q == S_DRAIN) || (state_q == S_FLUSH);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;
  localparam int N    = 4;
  localparam int REGS = 4;
  localparam int W    = 32 * N;
  localparam int LOGN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            st   [2];
  logic            rdy  [2];
  logic [W-1:0]    psum [2];
  logic [N-1:0]    a_wben [2];
  logic [N-1:0]    a_or   [2];
  logic            a_mv   [2];
  logic [W-1:0]    a_md   [2];
  logic [1:0]      a_mi   [2];
  logic            a_busy [2];
  logic            a_done [2];
  logic [15:0]     a_stall[2];

  pe_result_drain_if #(.N(N), .REGS(REGS)) bus0 ();
  pe_result_drain_if #(.N(N), .REGS(REGS)) bus1 ();

  pe_result_drain #(.N(N), .REGS(REGS), .DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .bus(bus0),
    .busy(a_busy[0]), .done(a_done[0]), .stall_cnt(a_stall[0]));

  pe_result_drain #(.N(N), .REGS(REGS), .DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .bus(bus1),
    .busy(a_busy[1]), .done(a_done[1]), .stall_cnt(a_stall[1]));

  assign bus0.m_ready = rdy[0];
  assign bus1.m_ready = rdy[1];
  assign bus0.pe_sum  = psum[0];
  assign bus1.pe_sum  = psum[1];
  assign a_wben[0] = bus0.wben;     assign a_wben[1] = bus1.wben;
  assign a_or[0]   = bus0.out_ready; assign a_or[1]  = bus1.out_ready;
  assign a_mv[0]   = bus0.m_valid;  assign a_mv[1]   = bus1.m_valid;
  assign a_md[0]   = bus0.m_data;   assign a_md[1]   = bus1.m_data;
  assign a_mi[0]   = bus0.m_idx;    assign a_mi[1]   = bus1.m_idx;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Word every PE column returns for a given slot: lane k = 0x1000_0000*k + slot.
  function automatic logic [W-1:0] beat_word(input int slot);
    logic [W-1:0] w;
    for (int k = 0; k < N; k++) w[32*k +: 32] = 32'h1000_0000 * 32'(k) + 32'(slot);
    return w;
  endfunction

  // PE column responders: each out_ready strobe presents the next slot.
  int pe_ptr [2];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin pe_ptr[i] <= 0; psum[i] <= '0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (st[i] && !a_busy[i] && !a_done[i]) pe_ptr[i] <= 0;
        else if (a_or[i][0]) begin
          psum[i]   <= beat_word(pe_ptr[i]);
          pe_ptr[i] <= pe_ptr[i] + 1;
        end
      end
    end
  end

  // Behavioural model: beats issued but not yet accepted are "in flight";
  // a strobe is allowed while fewer than DEPTH are in flight, and a beat
  // becomes visible two cycles after its strobe.
  int  cyc = 0;
  bit  md_act [2];
  bit  md_done[2];
  int  md_iss [2];
  int  md_acc [2];
  int  md_vis [2][REGS];
  logic [W-1:0] md_last [2];
  logic [1:0]   md_lidx [2];
  int  md_stall [2];
  int  start_cyc [2];

  int  or_tot [2];
  int  or_log [2][LOGN];
  int  acc_tot [2];
  logic [1:0]  acc_idx [2][LOGN];
  logic [31:0] acc_l2  [2][LOGN];
  int  done_tot [2];
  int  done_cyc [2];

  function automatic int depth_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      logic hv, e_or, e_wb, idle, nd;
      logic [W-1:0] e_d;
      logic [1:0]   e_i;
      int e_st;
      if (rst) begin
        md_act[i] = 0; md_done[i] = 0; md_iss[i] = 0; md_acc[i] = 0;
        md_last[i] = '0; md_lidx[i] = '0; md_stall[i] = 0;
      end
      hv = 1'b0;
      if (md_acc[i] < md_iss[i]) hv = (md_vis[i][md_acc[i]] <= cyc);
      e_d  = hv ? beat_word(md_acc[i]) : md_last[i];
      e_i  = hv ? 2'(md_acc[i]) : md_lidx[i];
      e_wb = md_act[i] && (md_iss[i] < REGS);
      e_or = e_wb && ((md_iss[i] - md_acc[i]) < depth_of(i));
`ifdef WB_STALL_CNT_EN
      e_st = md_stall[i];
`else
      e_st = 0;
`endif
      chk($sformatf("u%0d_wben", i),      W'(a_wben[i]),  W'({N{e_wb}}));
      chk($sformatf("u%0d_out_ready", i), W'(a_or[i]),    W'({N{e_or}}));
      chk($sformatf("u%0d_m_valid", i),   W'(a_mv[i]),    W'(hv));
      chk($sformatf("u%0d_m_data", i),    a_md[i],        e_d);
      chk($sformatf("u%0d_m_idx", i),     W'(a_mi[i]),    W'(e_i));
      chk($sformatf("u%0d_busy", i),      W'(a_busy[i]),  W'(md_act[i]));
      chk($sformatf("u%0d_done", i),      W'(a_done[i]),  W'(md_done[i]));
      chk($sformatf("u%0d_stall_cnt", i), W'(a_stall[i]), W'(e_st));

      if (a_or[i][0]) begin
        if (or_tot[i] < LOGN) or_log[i][or_tot[i]] = cyc;
        or_tot[i]++;
      end
      if (a_mv[i] && rdy[i]) begin
        if (acc_tot[i] < LOGN) begin
          acc_idx[i][acc_tot[i]] = a_mi[i];
          acc_l2[i][acc_tot[i]]  = a_md[i][64 +: 32];
        end
        acc_tot[i]++;
      end
      if (a_done[i]) begin done_tot[i]++; done_cyc[i] = cyc; end

      if (!rst) begin
        idle = !md_act[i] && !md_done[i];
        nd   = 1'b0;
        if (hv) begin md_last[i] = e_d; md_lidx[i] = e_i; end
        if (hv && !rdy[i] && md_stall[i] < 65535) md_stall[i]++;
        if (hv && rdy[i]) begin
          md_acc[i]++;
          if (md_acc[i] == REGS) begin md_act[i] = 0; nd = 1'b1; end
        end
        if (e_or) begin md_vis[i][md_iss[i]] = cyc + 2; md_iss[i]++; end
        if (st[i] && idle) begin
          md_act[i] = 1; md_iss[i] = 0; md_acc[i] = 0; md_stall[i] = 0;
          start_cyc[i] = cyc;
        end
        md_done[i] = nd;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int i);
    tick(); st[i] = 1'b1;
    tick(); st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int base = done_tot[i];
    for (int k = 0; k < budget && done_tot[i] == base; k++) tick();
    chk($sformatf("u%0d_done_within_budget", i), W'(done_tot[i] > base), W'(1));
  endtask

  task automatic chk_seq(input string nm, input int i, input int base);
    chk({nm, "_beats"}, W'(acc_tot[i] - base), W'(4));
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_idx%0d", nm, k), W'(acc_idx[i][base + k]), W'(k));
  endtask

  initial begin
    int b_or, b_acc, b_done, k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin st[i] = 1'b0; rdy[i] = 1'b0; end
    repeat (3) tick();
    chk("reset_busy", W'(a_busy[0]), W'(0));
    chk("reset_m_valid", W'(a_mv[1]), W'(0));
    chk("reset_m_data", a_md[0], '0);
    chk("reset_out_ready", W'(a_or[0]), W'(0));
    rst = 1'b0;
    repeat (2) tick();

    // basic drain, m_ready tied high
    rdy[0] = 1'b1; b_or = or_tot[0]; b_acc = acc_tot[0];
    pulse_start(0);
    wait_done(0, 30);
    chk("basic_or_count", W'(or_tot[0] - b_or), W'(4));
    chk("basic_or_span", W'(or_log[0][b_or + 3] - or_log[0][b_or]), W'(3));
    chk_seq("basic", 0, b_acc);
    chk("basic_beat3_lane2", W'(acc_l2[0][b_acc + 3]), W'(32'h2000_0003));
    chk("basic_done_latency", W'(done_cyc[0] - start_cyc[0]), W'(7));
    chk("basic_busy_after_done", W'(a_busy[0]), W'(0));
    repeat (2) tick();

    // backpressure on the DEPTH=2 unit
    rdy[1] = 1'b0; b_or = or_tot[1]; b_acc = acc_tot[1];
    pulse_start(1);
    repeat (8) tick();
    chk("bp_or_count_full", W'(or_tot[1] - b_or), W'(2));
    chk("bp_out_ready_low", W'(a_or[1]), W'(0));
    chk("bp_m_valid", W'(a_mv[1]), W'(1));
    chk("bp_m_idx_held", W'(a_mi[1]), W'(0));
    rdy[1] = 1'b1;
    wait_done(1, 30);
    chk("bp_or_count_total", W'(or_tot[1] - b_or), W'(4));
    chk_seq("bp", 1, b_acc);
    repeat (2) tick();

    // m_ready toggling 1,0,1,0
    b_acc = acc_tot[0]; b_done = done_tot[0];
    pulse_start(0);
    for (k = 0; k < 40 && done_tot[0] == b_done; k++) begin
      rdy[0] = (k % 2 == 0);
      tick();
    end
    chk("toggle_done", W'(done_tot[0] - b_done), W'(1));
    chk_seq("toggle", 0, b_acc);
    rdy[0] = 1'b1;
    repeat (2) tick();

    // second start during a drain is ignored
    b_or = or_tot[0]; b_acc = acc_tot[0]; b_done = done_tot[0];
    pulse_start(0);
    tick(); st[0] = 1'b1;
    tick(); st[0] = 1'b0;
    wait_done(0, 30);
    repeat (10) tick();
    chk("ign_or_count", W'(or_tot[0] - b_or), W'(4));
    chk_seq("ign", 0, b_acc);
    chk("ign_done_pulses", W'(done_tot[0] - b_done), W'(1));

    // asynchronous reset in the middle of a drain
    b_or = or_tot[0];
    pulse_start(0);
    @(posedge clk); @(posedge clk); #3;
    chk("rst_pre_issues", W'(or_tot[0] - b_or), W'(2));
    rst = 1'b1;
    #1;
    chk("rst_wben", W'(a_wben[0]), W'(0));
    chk("rst_out_ready", W'(a_or[0]), W'(0));
    chk("rst_m_valid", W'(a_mv[0]), W'(0));
    chk("rst_busy", W'(a_busy[0]), W'(0));
    tick(); tick();
    rst = 1'b0;
    tick();
    b_acc = acc_tot[0];
    pulse_start(0);
    wait_done(0, 30);
    chk_seq("post_rst", 0, b_acc);
    chk("post_rst_lane2", W'(acc_l2[0][b_acc + 3]), W'(32'h2000_0003));

    // stall counter under sustained backpressure
    rdy[1] = 1'b0;
    pulse_start(1);
    k = 0;
    do begin @(negedge clk); k++; end while (!a_mv[1] && k < 10);
    chk("stall_m_valid_up", W'(a_mv[1]), W'(1));
    repeat (5) @(negedge clk);
`ifdef WB_STALL_CNT_EN
    chk("stall_cnt_after_5", W'(a_stall[1]), W'(5));
`else
    chk("stall_cnt_after_5", W'(a_stall[1]), W'(0));
`endif
    @(posedge clk); #1;
    rdy[1] = 1'b1;
    wait_done(1, 30);
    pulse_start(1);
    chk("stall_cnt_cleared", W'(a_stall[1]), W'(0));
    wait_done(1, 30);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
